matmul_ctrl: RTL



---
 rtl/matmul_ctrl_if.sv | 35 +++
 rtl/matmul_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/matmul_ctrl_if.sv
// Bus bundle between the matmul sequencer, its host loader and the A/B/C RAMs.
// slave = the sequencer; master = the host/RAM side that drives it.
interface matmul_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 6,
  parameter int OW = 19
);
  logic          start;
  logic          host_wr;
  logic          host_sel;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_din;
  logic [DW-1:0] a_dout;
  logic [DW-1:0] b_dout;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] mdi_ab;
  logic          mwr_a;
  logic          mwr_b;
  logic [AW-1:0] addr_c;
  logic [OW-1:0] c_data;
  logic          c_wr;
  logic          busy;
  logic          done;

  modport slave (
    input  start, host_wr, host_sel, host_addr, host_din, a_dout, b_dout,
    output addr_a, addr_b, mdi_ab, mwr_a, mwr_b, addr_c, c_data, c_wr, busy, done
  );

  modport master (
    output start, host_wr, host_sel, host_addr, host_din, a_dout, b_dout,
    input  addr_a, addr_b, mdi_ab, mwr_a, mwr_b, addr_c, c_data, c_wr, busy, done
  );
endinterface

// File: rtl/matmul_ctrl.sv
// Sequencer for an NxN signed matrix multiply C = A x B over single-port RAMs.
// Owns RAM arbitration (host loads only while idle), address generation and the MAC.
module matmul_ctrl #(
  parameter int N  = 8,
  parameter int DW = 8,
  parameter int AW = 6,
  parameter int OW = 19
) (
  input  logic clk,
  input  logic rst_n,
  matmul_ctrl_if.slave bus
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] KMAX = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_LAST,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [CW-1:0]         k_q, k_d;
  logic                  valid_q, valid_d;
  logic signed [OW-1:0]  acc_q, acc_d;
  logic signed [2*DW-1:0] prod;
  logic                  last_k;
  logic                  last_el;

  assign last_k  = (k_q == KMAX);
  assign last_el = (row_q == KMAX) && (col_q == KMAX);
  assign prod    = $signed(bus.a_dout) * $signed(bus.b_dout);

  // ---------------------------------------------------------------------------
  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last_k) state_d = S_LAST;
      S_LAST:  state_d = S_WRITE;
      S_WRITE: state_d = last_el ? S_DONE : S_RUN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs and RAM port mux. Host owns the A/B ports outside compute;
  // during compute its writes are dropped rather than deferred.
  always_comb begin
    bus.busy   = 1'b0;
    bus.c_wr   = 1'b0;
    bus.done   = 1'b0;
    bus.addr_a = bus.host_addr;
    bus.addr_b = bus.host_addr;
    bus.mwr_a  = 1'b0;
    bus.mwr_b  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        bus.mwr_a = bus.host_wr & ~bus.host_sel;
        bus.mwr_b = bus.host_wr &  bus.host_sel;
        bus.done  = (state_q == S_DONE);
      end
      S_RUN, S_LAST, S_WRITE: begin
        bus.busy = 1'b1;
        // N is a power of two, so row*N+k is a plain concatenation
        bus.addr_a = {row_q, k_q};
        bus.addr_b = {k_q, col_q};
        bus.c_wr   = (state_q == S_WRITE);
      end
      default: ;
    endcase
  end

  assign bus.mdi_ab = bus.host_din;
  assign bus.addr_c = {row_q, col_q};
  assign bus.c_data = acc_q;

  // ---------------------------------------------------------------------------
  // Counters and MAC. valid trails RUN by one cycle to line up with RAM latency.
  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;
    valid_d = (state_q == S_RUN);
    acc_d   = valid_q ? acc_q + {{(OW-2*DW){prod[2*DW-1]}}, prod} : acc_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          row_d = '0;
          col_d = '0;
          k_d   = '0;
          acc_d = '0;
        end
      end
      S_RUN: k_d = k_q + 1'b1;
      S_WRITE: begin
        k_d   = '0;
        acc_d = '0;
        col_d = col_q + 1'b1;
        if (col_q == KMAX) row_d = row_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      acc_q   <= acc_d;
    end
  end

endmodule
